// File: rtl/pic_pkg.sv
// Shared encodings and constants for the interrupt-acknowledge sequencer.
// The POLL encoding is only reachable when INTA_POLL_EN is defined.
package pic_pkg;

  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] ACK1 = 3'b001;
  localparam logic [2:0] ACK2 = 3'b010;
  localparam logic [2:0] ACK3 = 3'b011;
  localparam logic [2:0] POLL = 3'b100;

  localparam logic [7:0] CALL_OPCODE    = 8'hCD;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  // Second INTA byte: 8086 vector, or the low CALL address byte in 8080 mode.
  function automatic logic [7:0] ack2_byte(input logic       is_8086,
                                           input logic       interval_4,
                                           input logic [2:0] addr_a7_a5,
                                           input logic [2:0] level,
                                           input logic [7:0] icw2);
    if (is_8086)
      return {icw2[7:3], level};
    else if (interval_4)
      return {addr_a7_a5, level, 2'b00};
    else
      return {addr_a7_a5[2:1], level, 3'b000};
  endfunction

endpackage

// File: rtl/inta_sequencer_strobe_edge_detect.sv
// Falling/rising edge detector for an already-synchronised active-low strobe.
module strobe_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe_n,
  output logic fall,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!reset_n) prev <= 1'b1;
    else          prev <= strobe_n;
  end

  assign fall = prev & ~strobe_n;
  assign rise = ~prev & strobe_n;

endmodule

// File: rtl/inta_sequencer.sv
// 8259A interrupt-acknowledge sequencer (8080/85 three-pulse, 8086 two-pulse).
// Optional poll read path enabled by defining INTA_POLL_EN.
//
// state | meaning
// IDLE  | no acknowledge in progress
// ACK1  | first INTA seen, level captured
// ACK2  | second INTA (8086 vector / 8080 low address byte)
// ACK3  | third INTA, 8080 only (high address byte)
// POLL  | poll read in progress (INTA_POLL_EN only)
module inta_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inta_n,
  input  logic       mode_8086,
  input  logic       interval_4,
  input  logic [2:0] addr_a7_a5,
  input  logic [7:0] icw2,
  input  logic       int_pending,
  input  logic [2:0] highest_level,
  input  logic       cascade_output_ack_2_3,
  output logic [2:0] control_state,
  output logic       latch_in_service,
  output logic [2:0] acked_level,
  output logic       irr_freeze,
  output logic       end_of_acknowledge,
  output logic [7:0] data_out,
  output logic       data_out_en
`ifdef INTA_POLL_EN
  ,
  input  logic       poll_cmd,
  input  logic       rd_n
`endif
);

  logic       inta_fall, inta_rise;
  logic [2:0] state_q, state_d;
  logic       mode_q, mode_d;
  logic [2:0] level_q, level_d;
  logic       lis_q, lis_d;
  logic       freeze_q, freeze_d;
  logic       eoa_q, eoa_d;
  logic [7:0] dout_q, dout_d;
  logic       den_q, den_d;
  logic       end_seq;

  strobe_edge_detect u_inta_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_n (inta_n),
    .fall     (inta_fall),
    .rise     (inta_rise)
  );

`ifdef INTA_POLL_EN
  logic rd_fall, rd_rise;
  logic armed_q, armed_d;

  strobe_edge_detect u_rd_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_n (rd_n),
    .fall     (rd_fall),
    .rise     (rd_rise)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) armed_q <= 1'b0;
    else          armed_q <= armed_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      level_q  <= 3'd0;
      lis_q    <= 1'b0;
      freeze_q <= 1'b0;
      eoa_q    <= 1'b0;
      dout_q   <= 8'h00;
      den_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      level_q  <= level_d;
      lis_q    <= lis_d;
      freeze_q <= freeze_d;
      eoa_q    <= eoa_d;
      dout_q   <= dout_d;
      den_q    <= den_d;
    end
  end

  // Final state is ACK2 in 8086 mode and ACK3 in 8080 mode; mode_q is frozen at ACK1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (inta_fall) state_d = ACK1;
`ifdef INTA_POLL_EN
        else if (armed_q && rd_fall) state_d = POLL;
`endif
      end
      ACK1: if (inta_fall) state_d = ACK2;
      ACK2: begin
        if (!mode_q && inta_fall)     state_d = ACK3;
        else if (mode_q && inta_rise) state_d = IDLE;
      end
      ACK3: if (inta_rise) state_d = IDLE;
`ifdef INTA_POLL_EN
      POLL: if (rd_rise) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign end_seq = (state_q != IDLE) && (state_d == IDLE);

  always_comb begin
    mode_d   = mode_q;
    level_d  = level_q;
    lis_d    = 1'b0;
    freeze_d = freeze_q;
    eoa_d    = 1'b0;
    dout_d   = dout_q;
    den_d    = den_q;
`ifdef INTA_POLL_EN
    armed_d  = armed_q;
    if (state_q == IDLE && state_d == IDLE && poll_cmd) armed_d = 1'b1;
    if (state_d == ACK1 || state_d == POLL) armed_d = 1'b0;
`endif
    if (state_q == IDLE && state_d == ACK1) begin
      mode_d   = mode_8086;
      level_d  = int_pending ? highest_level : SPURIOUS_LEVEL;
      lis_d    = int_pending;
      freeze_d = 1'b1;
      dout_d   = mode_8086 ? 8'h00 : CALL_OPCODE;
      den_d    = ~mode_8086;
    end else if (state_q == ACK1 && state_d == ACK2) begin
      dout_d = ack2_byte(mode_q, interval_4, addr_a7_a5, level_q, icw2);
      den_d  = cascade_output_ack_2_3;
    end else if (state_q == ACK2 && state_d == ACK3) begin
      dout_d = icw2;
      den_d  = cascade_output_ack_2_3;
`ifdef INTA_POLL_EN
    end else if (state_q == IDLE && state_d == POLL) begin
      level_d  = highest_level;
      lis_d    = int_pending;
      freeze_d = 1'b1;
      dout_d   = {int_pending, 4'b0000, highest_level};
      den_d    = 1'b1;
`endif
    end else if (end_seq) begin
      freeze_d = 1'b0;
      eoa_d    = 1'b1;
      den_d    = 1'b0;
    end else if (inta_rise) begin
      den_d = 1'b0;
    end
  end

  assign control_state      = state_q;
  assign latch_in_service   = lis_q;
  assign acked_level        = level_q;
  assign irr_freeze         = freeze_q;
  assign end_of_acknowledge = eoa_q;
  assign data_out           = dout_q;
  assign data_out_en        = den_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: stimulus queues expected bytes/pulses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       inta_n = 1'b1;
  logic       mode_8086 = 1'b0;
  logic       interval_4 = 1'b0;
  logic [2:0] addr_a7_a5 = 3'd0;
  logic [7:0] icw2 = 8'h00;
  logic       int_pending = 1'b0;
  logic [2:0] highest_level = 3'd0;
  logic       cascade_output_ack_2_3 = 1'b1;
  logic [2:0] control_state;
  logic       latch_in_service;
  logic [2:0] acked_level;
  logic       irr_freeze;
  logic       end_of_acknowledge;
  logic [7:0] data_out;
  logic       data_out_en;
`ifdef INTA_POLL_EN
  logic       poll_cmd = 1'b0;
  logic       rd_n = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_byte_q[$];
  logic [2:0] exp_lis_q[$];
  logic       exp_eoa_q[$];
  logic       en_prev = 1'b0;

  inta_sequencer dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .inta_n                 (inta_n),
    .mode_8086              (mode_8086),
    .interval_4             (interval_4),
    .addr_a7_a5             (addr_a7_a5),
    .icw2                   (icw2),
    .int_pending            (int_pending),
    .highest_level          (highest_level),
    .cascade_output_ack_2_3 (cascade_output_ack_2_3),
    .control_state          (control_state),
    .latch_in_service       (latch_in_service),
    .acked_level            (acked_level),
    .irr_freeze             (irr_freeze),
    .end_of_acknowledge     (end_of_acknowledge),
    .data_out               (data_out),
    .data_out_en            (data_out_en)
`ifdef INTA_POLL_EN
    ,
    .poll_cmd               (poll_cmd),
    .rd_n                   (rd_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or pulse.
  always @(negedge clk) begin
    if (data_out_en && !en_prev) begin
      if (exp_byte_q.size() != 0) check("data_byte", data_out, exp_byte_q.pop_front());
      else begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%02h required=none", data_out);
      end
    end
    en_prev = data_out_en;
    if (latch_in_service) begin
      if (exp_lis_q.size() != 0) check("lis_level", acked_level, exp_lis_q.pop_front());
      else begin
        checks++;
        errors++;
        $display("FAIL unexpected_latch_in_service actual=1 required=0 level=%0d", acked_level);
      end
    end
    if (end_of_acknowledge) begin
      if (exp_eoa_q.size() != 0) begin
        void'(exp_eoa_q.pop_front());
        check("eoa_state_idle", control_state, 3'd0);
        check("eoa_freeze_low", irr_freeze, 1'b0);
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_end_of_acknowledge actual=1 required=0");
      end
    end
  end

  task automatic inta_pulse(input logic [2:0] exp_state, input logic last, input string tag);
    inta_n = 1'b0;
    tick();
    check({tag, "_state"}, control_state, exp_state);
    check({tag, "_freeze"}, irr_freeze, 1'b1);
    tick();
    tick();
    inta_n = 1'b1;
    tick();
    if (last) begin
      check({tag, "_eoa"}, end_of_acknowledge, 1'b1);
      check({tag, "_idle"}, control_state, 3'd0);
    end else begin
      check({tag, "_hold"}, control_state, exp_state);
      check({tag, "_en_drop"}, data_out_en, 1'b0);
    end
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, control_state, 3'd0);
    check({tag, "_lis"}, latch_in_service, 1'b0);
    check({tag, "_level"}, acked_level, 3'd0);
    check({tag, "_freeze"}, irr_freeze, 1'b0);
    check({tag, "_eoa"}, end_of_acknowledge, 1'b0);
    check({tag, "_dout"}, data_out, 8'h00);
    check({tag, "_den"}, data_out_en, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    tick();

    // 8086, level 5, icw2 0x40: vector 0x45 on the second pulse only.
    mode_8086 = 1'b1; int_pending = 1'b1; highest_level = 3'd5; icw2 = 8'h40;
    cascade_output_ack_2_3 = 1'b1;
    exp_lis_q.push_back(3'd5);
    exp_byte_q.push_back(8'h45);
    exp_eoa_q.push_back(1'b1);
    inta_n = 1'b0;
    tick();
    check("t1_ack1_den", data_out_en, 1'b0);
    check("t1_ack1_level", acked_level, 3'd5);
    tick();
    inta_n = 1'b1;
    tick();
    tick();
    inta_pulse(3'd2, 1'b1, "t1_p2");

    // 8080, interval 4, A7..A5=101, level 3, icw2 0x12: CD, AC, 12.
    mode_8086 = 1'b0; interval_4 = 1'b1; addr_a7_a5 = 3'b101; icw2 = 8'h12;
    highest_level = 3'd3;
    exp_lis_q.push_back(3'd3);
    exp_byte_q.push_back(8'hCD);
    exp_byte_q.push_back(8'hAC);
    exp_byte_q.push_back(8'h12);
    exp_eoa_q.push_back(1'b1);
    inta_pulse(3'd1, 1'b0, "t2_p1");
    inta_pulse(3'd2, 1'b0, "t2_p2");
    inta_pulse(3'd3, 1'b1, "t2_p3");

    // 8080, interval 8: ACK2 byte 0x98; mode_8086 flipped mid-sequence is ignored.
    interval_4 = 1'b0;
    exp_lis_q.push_back(3'd3);
    exp_byte_q.push_back(8'hCD);
    exp_byte_q.push_back(8'h98);
    exp_byte_q.push_back(8'h12);
    exp_eoa_q.push_back(1'b1);
    inta_pulse(3'd1, 1'b0, "t3_p1");
    mode_8086 = 1'b1;
    inta_pulse(3'd2, 1'b0, "t3_p2");
    inta_pulse(3'd3, 1'b1, "t3_p3");

    // 8086 master with slave request: bus stays released, sequence still ends.
    icw2 = 8'h40; highest_level = 3'd2; cascade_output_ack_2_3 = 1'b0;
    exp_lis_q.push_back(3'd2);
    exp_eoa_q.push_back(1'b1);
    inta_pulse(3'd1, 1'b0, "t4_p1");
    inta_pulse(3'd2, 1'b1, "t4_p2");

    // Spurious: no pending request, level 7, vector 0x47, no ISR latch.
    cascade_output_ack_2_3 = 1'b1; int_pending = 1'b0; highest_level = 3'd4;
    exp_byte_q.push_back(8'h47);
    exp_eoa_q.push_back(1'b1);
    inta_pulse(3'd1, 1'b0, "t5_p1");
    check("t5_spurious_level", acked_level, 3'd7);
    inta_pulse(3'd2, 1'b1, "t5_p2");

    // Reset while in ACK2 (8080), then a fresh 8086 sequence.
    mode_8086 = 1'b0; interval_4 = 1'b1; addr_a7_a5 = 3'b101; icw2 = 8'h12;
    int_pending = 1'b1; highest_level = 3'd3;
    exp_lis_q.push_back(3'd3);
    exp_byte_q.push_back(8'hCD);
    exp_byte_q.push_back(8'hAC);
    inta_pulse(3'd1, 1'b0, "t6_p1");
    inta_n = 1'b0;
    tick();
    check("t6_in_ack2", control_state, 3'd2);
    tick();
    reset_n = 1'b0;
    tick();
    check_reset_outputs("t6_midrst");
    reset_n = 1'b1;
    inta_n = 1'b1;
    tick();
    tick();
    check("t6_still_idle", control_state, 3'd0);
    mode_8086 = 1'b1; icw2 = 8'h40; highest_level = 3'd5;
    exp_lis_q.push_back(3'd5);
    exp_byte_q.push_back(8'h45);
    exp_eoa_q.push_back(1'b1);
    inta_pulse(3'd1, 1'b0, "t6_fresh_p1");
    inta_pulse(3'd2, 1'b1, "t6_fresh_p2");

    tick();
    tick();
    check("byte_q_drained", exp_byte_q.size(), 0);
    check("lis_q_drained", exp_lis_q.size(), 0);
    check("eoa_q_drained", exp_eoa_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Sequences the 8259A interrupt-acknowledge cycle for the control logic.
- Samples the INTA strobe, steps control_state through ACK1/ACK2/ACK3, and latches the winning IR level into ISR.
- Drives the vector/CALL bytes onto the internal data bus, gated by the cascade block's cascade_output_ack_2_3.
- Handles both 8080/85 (3-pulse) and 8086 (2-pulse) modes.

Parameters:
- None. The state encoding is fixed in the package.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- inta_n  input  1  INTA strobe, already synchronised to clk
- mode_8086  input  1  ICW4 uPM: 1 = 8086, 0 = 8080/85
- interval_4  input  1  ICW1 ADI: 1 = 4-byte interval, 0 = 8-byte interval
- addr_a7_a5  input  3  ICW1 A7..A5
- icw2  input  8  ICW2 (8086: T7..T3 in [7:3]; 8080: A15..A8)
- int_pending  input  1  priority resolver has an unmasked request
- highest_level  input  3  winning IR number
- cascade_output_ack_2_3  input  1  this device drives the ACK2/ACK3 bytes
- control_state  output  3  IDLE/ACK1/ACK2/ACK3 (feeds cascade block)
- latch_in_service  output  1  one-cycle pulse: set ISR bit acked_level
- acked_level  output  3  level captured at ACK1
- irr_freeze  output  1  high from ACK1 entry until end of sequence
- end_of_acknowledge  output  1  one-cycle pulse at end of last INTA (AEOI hook)
- data_out  output  8  byte for the data-bus buffer
- data_out_en  output  1  data-bus drive enable

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0, control_state=IDLE, inta_prev=1.
- Edge detection: fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n; inta_prev registered every cycle.
- IDLE, fall -> ACK1:
  - acked_level <= int_pending ? highest_level : 3'd7 (spurious = IR7).
  - latch_in_service pulses the next cycle, only if int_pending was 1.
  - irr_freeze <= 1.
- ACK1, fall -> ACK2.
- ACK2, fall -> ACK3 in 8080 mode only.
- 8086 mode: rise while in ACK2 ends the sequence.
- 8080 mode: rise while in ACK3 ends the sequence.
- End of sequence (registered):
  - control_state <= IDLE, irr_freeze <= 0.
  - end_of_acknowledge pulses for 1 cycle.
  - data_out_en <= 0.
- A rise in any non-final ACK state changes no state; data_out_en drops.
- A fall while already in the final ACK state is ignored.
- Data, registered on the fall that enters the state; data_out_en held until the next rise:
  - 8080 ACK1: 0xCD, always driven.
  - 8080 ACK2, interval_4=1: {addr_a7_a5, acked_level, 2'b00}.
  - 8080 ACK2, interval_4=0: {addr_a7_a5[2:1], acked_level, 3'b000}.
  - 8080 ACK3: icw2.
  - 8086 ACK1: data_out_en=0.
  - 8086 ACK2: {icw2[7:3], acked_level}.
- In ACK2/ACK3, data_out_en = cascade_output_ack_2_3 sampled at the fall. A master with a slave request keeps the bus released.
- mode_8086 changing mid-sequence: sampled at ACK1 entry and held until IDLE.
- Reset mid-sequence returns to IDLE immediately.
- Simultaneous fall and rise cannot occur; at most one edge per cycle by construction.

Optional Feature:
- Macro INTA_POLL_EN adds a poll read path.
- Added ports: poll_cmd (OCW3 P-bit pulse), rd_n (synchronised).
- With the macro:
  - poll_cmd arms a poll from IDLE. The next rd_n fall enters state POLL (3'b100) and drives data_out={int_pending,4'b0,highest_level}, data_out_en=1.
  - latch_in_service pulses if int_pending; irr_freeze=1.
  - The rd_n rise ends the poll: IDLE, end_of_acknowledge pulse.
  - An inta_n fall while armed cancels the poll and starts a normal ACK1.
- Without the macro: no extra ports; POLL encoding is unreachable.

Decomposition:
- Package pic_pkg:
  - control-state localparams IDLE=3'b000, ACK1=3'b001, ACK2=3'b010, ACK3=3'b011, POLL=3'b100.
  - CALL_OPCODE=8'hCD, SPURIOUS_LEVEL=3'd7.
- Sub-module strobe_edge_detect (registered prev value, fall/rise outputs), instantiated for inta_n and for rd_n.

Test Plan:
- 8086, int_pending=1, level=5, icw2=0x40, cascade_output_ack_2_3=1; two INTA pulses:
  - latch_in_service one pulse, ACK1 data_out_en=0, ACK2 data_out=0x45.
  - end_of_acknowledge one cycle after the second rise.
- 8080, interval_4=1, addr_a7_a5=3'b101, icw2=0x12, level=3; three pulses -> bytes 0xCD, 0xAC, 0x12; control_state 1,2,3,0.
- 8080, interval_4=0, same config -> ACK2 byte 0x98.
- Master with slave request (cascade_output_ack_2_3=0), 8086 -> data_out_en stays 0 for the whole sequence; state still steps and ends normally.
- INTA with int_pending=0 -> no latch_in_service pulse, acked_level=7, 8086 vector {icw2[7:3],3'b111}.
- reset_n low during ACK2 -> next cycle all outputs 0, IDLE; the following INTA starts a fresh ACK1.
